// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back issue unit.
//   - field widths of the memory write-back frame and its bit positions
//   - FSM state enum for the flush sequencer
//   - queue entry struct and a helper that packs an entry into a frame
package wb_pkg;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 16;
    localparam int SRC_W   = 3;
    localparam int FRAME_W = 22;

    localparam int ADDR_HI = 21;
    localparam int ADDR_LO = 19;
    localparam int SRC_HI  = 18;
    localparam int SRC_LO  = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } wb_state_e;

    // Member order matches the frame layout {addr, src, data}.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [FRAME_W-1:0] pack_frame(input wb_entry_t e);
        logic [FRAME_W-1:0] f;
        f                  = '0;
        f[ADDR_HI:ADDR_LO] = e.addr;
        f[SRC_HI:SRC_LO]   = e.src;
        f[DATA_W-1:0]      = e.data;
        return f;
    endfunction

endpackage

// File: rtl/wb_coalesce_queue.sv
// wb_coalesce_queue: DEPTH-entry in-order queue with in-place coalescing.
//   clock, reset      : system clock, synchronous active-high reset
//   push_i            : append push_entry_i at the tail
//   upd_i             : overwrite src/data of the entry flagged by hit_o
//   pop_i             : drop the head entry (head_o is valid while !empty_o)
//   match_addr_i      : address looked up against queued entries
//   hit_o             : a queued entry matches, excluding a head popped this cycle
//   count_o, full_o, empty_o : occupancy 0..DEPTH and its flags
module wb_coalesce_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic              upd_i,
    input  wb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] match_addr_i,
    output logic              hit_o,
    output wb_entry_t         head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   hit_idx;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A head leaving this cycle cannot absorb a write; such a request must
    // become a fresh entry behind it. Only one entry per address exists, so
    // at most one slot can match.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit_o   = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].addr == match_addr_i) &&
                !(pop_i && (PTR_W'(i) == rd_ptr_q))) begin
                hit_o   = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
        end
    end

    // NOTE: payload storage is not reset; valid_q alone decides which slots mean anything.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end else if (upd_i) begin
            mem_q[hit_idx].src  <= push_entry_i.src;
            mem_q[hit_idx].data <= push_entry_i.data;
        end
    end

endmodule

// File: rtl/wb_issue_unit.sv
// wb_issue_unit: write-back initiator for the directory memory port.
//   clock, reset            : system clock, synchronous active-high reset
//   evict_valid/evict_ready : eviction handshake (ready is combinational)
//   evict_addr/data/src     : word address, data, originating node id
//   wb_stall                : memory busy, no frame issued while high
//   flush_req / flush_done  : drain request level / one-cycle completion pulse
//   dataWB_enable/dataWB_data : registered write strobe and frame {addr,src,data}
//   idle                    : queue empty and no frame on the output
module wb_issue_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               evict_valid,
    output logic               evict_ready,
    input  logic [ADDR_W-1:0]  evict_addr,
    input  logic [DATA_W-1:0]  evict_data,
    input  logic [SRC_W-1:0]   evict_src,
    input  logic               wb_stall,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               dataWB_enable,
    output logic [FRAME_W-1:0] dataWB_data,
    output logic               idle
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_e          state_q, state_d;
    logic               wb_en_q, wb_en_d;
    logic [FRAME_W-1:0] wb_data_q, wb_data_d;

    logic               hit, full, empty, pop, accept;
    logic [CNT_W-1:0]   count;
    wb_entry_t          head, req;

    assign req    = '{addr: evict_addr, src: evict_src, data: evict_data};
    assign pop    = !empty && !wb_stall;
    // A full queue can only take a request that coalesces into an existing entry.
    assign evict_ready = (state_q == RUN) && (!full || hit);
    assign accept = evict_valid && evict_ready;

    wb_coalesce_queue #(.DEPTH(DEPTH)) u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (accept && !hit),
        .upd_i        (accept && hit),
        .push_entry_i (req),
        .pop_i        (pop),
        .match_addr_i (evict_addr),
        .hit_o        (hit),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_comb begin
        wb_en_d   = pop;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_data_d = pack_frame(head);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (flush_req) state_d = FLUSH;
            FLUSH: if (empty && !wb_en_q) state_d = DONE;
            DONE:  state_d = flush_req ? HOLD : RUN;
            HOLD:  if (!flush_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign flush_done    = (state_q == DONE);
    assign dataWB_enable = wb_en_q;
    assign dataWB_data   = wb_data_q;
    assign idle          = (count == '0) && !wb_en_q;

endmodule
